// File: rtl/fetch_sequencer.sv
// Variable-length (1-4 byte) instruction fetch sequencer over a byte-wide memory port.
// Optional feature: define FETCH_ILLEGAL_TRAP_EN to flag the unsupported !ext & mod==10 encoding.
module fetch_sequencer #(
    parameter int unsigned     ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr_byte0,
    output logic [7:0]        instr_byte1,
    output logic [7:0]        instr_byte2,
    output logic [7:0]        instr_byte3,
    output logic [2:0]        instr_len,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              instr_illegal,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target
);

    typedef enum logic [1:0] {StF0, StF1, StFn, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic [2:0]        len_q, len_d;
    logic              illegal_q, illegal_d;
    logic              last_q, last_d;   // FN is capturing byte3 rather than byte2
    logic [1:0]        mod;
    logic              ext;
    logic [2:0]        f1_len;
    logic              f1_illegal;

    assign mod = mem_rdata[7:6];
    assign ext = b0_q[7];

    always_comb begin
        f1_len = 3'd2;
        unique case (mod)
            2'b00, 2'b10: f1_len = 3'd2;
            2'b01:        f1_len = ext ? 3'd4 : 3'd3;
            2'b11:        f1_len = 3'd4;
            default:      f1_len = 3'd2;
        endcase
`ifdef FETCH_ILLEGAL_TRAP_EN
        f1_illegal = !ext && (mod == 2'b10);
`else
        f1_illegal = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ipc_d     = ipc_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        b3_d      = b3_q;
        len_d     = len_q;
        illegal_d = illegal_q;
        last_d    = last_q;
        if (branch_valid) begin
            // Redirect wins over any capture this cycle; the abandoned instruction is wiped.
            state_d   = StF0;
            pc_d      = branch_target;
            b0_d      = 8'h00;
            b1_d      = 8'h00;
            b2_d      = 8'h00;
            b3_d      = 8'h00;
            len_d     = 3'd0;
            illegal_d = 1'b0;
            last_d    = 1'b0;
        end else begin
            unique case (state_q)
                StF0: if (mem_ready) begin
                    b0_d      = mem_rdata;
                    b1_d      = 8'h00;
                    b2_d      = 8'h00;
                    b3_d      = 8'h00;
                    illegal_d = 1'b0;
                    ipc_d     = pc_q;
                    pc_d      = pc_q + 1'b1;
                    len_d     = 3'd1;
                    last_d    = 1'b0;
                    state_d   = (mem_rdata[6:0] == 7'd0) ? StHold : StF1;
                end
                StF1: if (mem_ready) begin
                    b1_d      = mem_rdata;
                    pc_d      = pc_q + 1'b1;
                    len_d     = f1_len;
                    illegal_d = f1_illegal;
                    state_d   = (f1_len == 3'd2) ? StHold : StFn;
                end
                StFn: if (mem_ready) begin
                    pc_d = pc_q + 1'b1;
                    if (!last_q) begin
                        b2_d = mem_rdata;
                        if (len_q == 3'd3) state_d = StHold;
                        else               last_d  = 1'b1;
                    end else begin
                        b3_d    = mem_rdata;
                        state_d = StHold;
                    end
                end
                StHold: if (instr_ready) state_d = StF0;
                default: state_d = StF0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StF0;
            pc_q      <= RESET_PC;
            ipc_q     <= RESET_PC;
            b0_q      <= 8'h00;
            b1_q      <= 8'h00;
            b2_q      <= 8'h00;
            b3_q      <= 8'h00;
            len_q     <= 3'd0;
            illegal_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ipc_q     <= ipc_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            b3_q      <= b3_d;
            len_q     <= len_d;
            illegal_q <= illegal_d;
            last_q    <= last_d;
        end
    end

    assign mem_rd        = (state_q != StHold);
    assign mem_addr      = pc_q;
    assign instr_valid   = (state_q == StHold);
    assign instr_byte0   = b0_q;
    assign instr_byte1   = b1_q;
    assign instr_byte2   = b2_q;
    assign instr_byte3   = b3_q;
    assign instr_len     = len_q;
    assign instr_illegal = illegal_q;
    assign instr_pc      = ipc_q;

endmodule
